// File: rtl/dfa_pkg.sv
// Width helpers and ratio checks shared by the Avalon-ST data format adapters.
// Optional sideband (channel/error) is enabled with the DFA_SIDEBAND_EN macro.
package dfa_pkg;

  function automatic int sym_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int in_empty_w(input int in_symbols);
    return sym_w(in_symbols);
  endfunction

  function automatic int out_empty_w(input int out_symbols);
    return sym_w(out_symbols);
  endfunction

  function automatic int ratio(
    input int in_symbols,
    input int out_symbols
  );
    return (out_symbols > 0) ? in_symbols / out_symbols : 1;
  endfunction

  function automatic int cnt_w(
    input int in_symbols,
    input int out_symbols
  );
    return sym_w(ratio(in_symbols, out_symbols));
  endfunction

  function automatic bit ratio_ok(
    input int in_symbols,
    input int out_symbols
  );
    return (out_symbols > 0) &&
           (in_symbols >= out_symbols) &&
           ((in_symbols % out_symbols) == 0);
  endfunction

endpackage

// File: rtl/avalon_st_out_reg.sv
// Generic ready/valid output register; loads whenever the slot is free
// or the downstream consumes the current beat.
module avalon_st_out_reg
  import dfa_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  output logic         load,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_payload
);

  assign load = out_ready || !out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (load) begin
      out_valid   <= in_valid;
      out_payload <= in_payload;
    end
  end

endmodule

// File: rtl/avalon_st_wide_to_narrow_dfa.sv
// Splits wide Avalon-ST beats into IN_SYMBOLS/OUT_SYMBOLS narrow beats.
// Define DFA_SIDEBAND_EN to add channel/error ports repeated on each slice.
module avalon_st_wide_to_narrow_dfa
  import dfa_pkg::*;
#(
  parameter int SYMBOL_W    = 8,
  parameter int IN_SYMBOLS  = 8,
  parameter int OUT_SYMBOLS = 4,
  parameter int CHANNEL_W   = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic in_ready,
  input  logic in_valid,
  input  logic [IN_SYMBOLS*SYMBOL_W-1:0] in_data,
  input  logic in_startofpacket,
  input  logic in_endofpacket,
  input  logic [in_empty_w(IN_SYMBOLS)-1:0] in_empty,
  input  logic out_ready,
  output logic out_valid,
  output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
  output logic out_startofpacket,
  output logic out_endofpacket,
  output logic [out_empty_w(OUT_SYMBOLS)-1:0] out_empty
`ifdef DFA_SIDEBAND_EN
  ,
  input  logic [CHANNEL_W-1:0] in_channel,
  input  logic in_error,
  output logic [CHANNEL_W-1:0] out_channel,
  output logic out_error
`endif
);

  localparam int IN_W  = IN_SYMBOLS * SYMBOL_W;
  localparam int OUT_W = OUT_SYMBOLS * SYMBOL_W;
  localparam int RATIO = ratio(IN_SYMBOLS, OUT_SYMBOLS);
  localparam int CNT_W = cnt_w(IN_SYMBOLS, OUT_SYMBOLS);
  localparam int IEW   = in_empty_w(IN_SYMBOLS);
  localparam int OEW   = out_empty_w(OUT_SYMBOLS);
  localparam int CORE_W = OUT_W + 2 + OEW;
`ifdef DFA_SIDEBAND_EN
  localparam int PW = CORE_W + CHANNEL_W + 1;
`else
  localparam int PW = CORE_W;
`endif

  if (!ratio_ok(IN_SYMBOLS, OUT_SYMBOLS)) begin : g_bad_ratio
    $error("IN_SYMBOLS must be a multiple of OUT_SYMBOLS");
  end
  if (CHANNEL_W < 1) begin : g_bad_channel
    $error("CHANNEL_W must be at least 1");
  end

  logic             held_valid;
  logic [IN_W-1:0]  held_data;
  logic             held_sop;
  logic             held_eop;
  logic [IEW-1:0]   held_empty;
  logic [CNT_W-1:0] k;
`ifdef DFA_SIDEBAND_EN
  logic [CHANNEL_W-1:0] held_channel;
  logic                 held_error;
`endif

  logic             load;
  logic             accept;
  logic             advance;
  logic             at_last;
  logic [CNT_W-1:0] last;
  logic [31:0]      valid_syms;
  logic [31:0]      in_empty_ext;
  logic [IEW-1:0]   in_empty_cl;
  logic [OUT_W-1:0] slice;
  logic             sop_o;
  logic             eop_o;
  logic [OEW-1:0]   emp_o;
  logic [CORE_W-1:0] core;
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    pay_out;

  // Out-of-range empty is clamped so the slice arithmetic stays bounded.
  assign in_empty_ext = 32'(in_empty);
  assign in_empty_cl  = (in_empty_ext >= 32'(IN_SYMBOLS)) ?
                        IEW'(IN_SYMBOLS - 1) : in_empty;

  assign valid_syms = 32'(IN_SYMBOLS) - 32'(held_empty);

  assign last = held_eop ?
    CNT_W'((valid_syms - 32'd1) / 32'(OUT_SYMBOLS)) :
    CNT_W'(RATIO - 1);

  assign at_last  = (k == last);
  assign advance  = held_valid && load;
  assign in_ready = !held_valid || (at_last && load);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
      held_data  <= '0;
      held_sop   <= 1'b0;
      held_eop   <= 1'b0;
      held_empty <= '0;
      k          <= '0;
    end else begin
      if (advance) begin
        k <= at_last ? '0 : k + 1'b1;
      end
      if (accept) begin
        held_valid <= 1'b1;
        held_data  <= in_data;
        held_sop   <= in_startofpacket;
        held_eop   <= in_endofpacket;
        held_empty <= in_endofpacket ? in_empty_cl : '0;
      end else if (advance && at_last) begin
        held_valid <= 1'b0;
      end
    end
  end

`ifdef DFA_SIDEBAND_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_channel <= '0;
      held_error   <= 1'b0;
    end else if (accept) begin
      held_channel <= in_channel;
      held_error   <= in_error;
    end
  end
`endif

  // Symbol 0 sits in the MSBs, so slice i starts i*OUT_W below the top.
  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (k == CNT_W'(i)) begin
        slice = held_data[IN_W-1-i*OUT_W -: OUT_W];
      end
    end
  end

  assign sop_o = held_sop && (k == '0);
  assign eop_o = held_eop && at_last;
  assign emp_o = eop_o ?
    OEW'((32'(last) + 32'd1) * 32'(OUT_SYMBOLS) - valid_syms) :
    '0;

  assign core = {slice, sop_o, eop_o, emp_o};

`ifdef DFA_SIDEBAND_EN
  assign pay_in = held_valid ?
    {core, held_channel, held_error} : '0;
`else
  assign pay_in = held_valid ? core : '0;
`endif

  avalon_st_out_reg #(
    .W(PW)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (reset_n),
    .in_valid   (held_valid),
    .in_payload (pay_in),
    .load       (load),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_payload(pay_out)
  );

`ifdef DFA_SIDEBAND_EN
  assign {out_data, out_startofpacket, out_endofpacket,
          out_empty, out_channel, out_error} = pay_out;
`else
  assign {out_data, out_startofpacket, out_endofpacket,
          out_empty} = pay_out;
`endif

  a_empty_legal: assert property (
    @(posedge clk) disable iff (!reset_n)
    (in_valid && in_ready && in_endofpacket) |->
    (in_empty_ext < 32'(IN_SYMBOLS))
  );

endmodule

// File: doc/avalon_st_wide_to_narrow_dfa.md
Name: avalon_st_wide_to_narrow_dfa

Overview:
Parametrised Avalon-ST data format adapter that splits each wide input beat into RATIO = IN_SYMBOLS/OUT_SYMBOLS narrow output beats.
- Honours empty on the last beat and terminates early, emitting no padding-only beats.
- Sits between wide DMA/frame-buffer read masters and narrow sinks (e.g. LCD pixel pipeline).
- Generalises the fixed 64-to-32 adapter to any symbol width and any integer ratio.

Parameters:
SYMBOL_W, 8, bits per symbol
IN_SYMBOLS, 8, symbols per input beat
OUT_SYMBOLS, 4, symbols per output beat; IN_SYMBOLS % OUT_SYMBOLS must be 0 (elaboration error otherwise)
CHANNEL_W, 1, channel width (used only with DFA_SIDEBAND_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_ready  out  1  sink ready
in_valid  in  1  input beat valid
in_data  in  IN_SYMBOLS*SYMBOL_W  symbol 0 in the MSBs
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  max(1,clog2(IN_SYMBOLS))  unused symbols on the EOP beat
out_ready  in  1  downstream ready
out_valid  out  1  output beat valid
out_data  out  OUT_SYMBOLS*SYMBOL_W  symbol 0 in the MSBs
out_startofpacket  out  1  first narrow beat of packet
out_endofpacket  out  1  last narrow beat of packet
out_empty  out  max(1,clog2(OUT_SYMBOLS))  unused symbols on the EOP beat

Behaviour:
- Reset: all outputs 0; holding register invalid; slice counter 0.
- Input stage: a holding register captures in_* on (in_valid && in_ready).
  - in_empty is captured only when in_endofpacket; otherwise it is stored as 0.
  - in_empty >= IN_SYMBOLS is illegal. The simulation assertion fires and the value is clamped to IN_SYMBOLS-1.
- Slice counter k: runs 0..RATIO-1. Slice k is held symbols [k*OUT_SYMBOLS .. (k+1)*OUT_SYMBOLS-1], placed MSB-first on out_data.
- Last slice: LAST = RATIO-1 for a non-EOP beat. For an EOP beat, LAST = (IN_SYMBOLS-held_empty-1)/OUT_SYMBOLS (integer divide).
- Output register: loads when (out_ready || !out_valid).
  - out_valid = held valid.
  - out_startofpacket = held SOP && k==0.
  - out_endofpacket = held EOP && k==LAST.
  - out_empty = (LAST+1)*OUT_SYMBOLS - (IN_SYMBOLS-held_empty) on the EOP slice; 0 otherwise.
- Counter update on each load with held valid: if k==LAST, k returns to 0 and the holding register is released; else k increments.
- in_ready = !held_valid || (k==LAST && (out_ready || !out_valid)). This is combinational from out_ready and gives back-to-back beats with no bubble.
- Latency: an input accepted at edge t appears on out_* after edge t+1, i.e. two registers.
- Throughput: one narrow beat per cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, out_* and k are frozen.
- SOP and EOP on the same input beat are legal. A single-slice packet has out_startofpacket=out_endofpacket=1.
- A reset asserted mid-packet discards the partial beat. The counter returns to 0 and no partial output remains.
- RATIO=1 degenerates to a two-stage register pipe: empty is passed through truncated, and in_empty must be < OUT_SYMBOLS.

Optional Feature:
Macro: DFA_SIDEBAND_EN.
- Defined: adds ports in_channel/out_channel (CHANNEL_W) and in_error/out_error (1).
  - Channel and error are captured with the wide beat and repeated on every slice.
  - out_error is set on all slices of an errored beat.
  - Reset value is 0.
- Undefined: these ports are absent. No channel or error storage is present.

Decomposition:
- Package dfa_pkg:
  - clog2-based width functions (IN_EMPTY_W, OUT_EMPTY_W, RATIO, CNT_W).
  - Elaboration checks for the ratio constraint.
- Sub-module avalon_st_out_reg: the generic ready/valid output register with payload width parameter. It is reusable by a future narrow-to-wide adapter.

Test Plan:
- Defaults, input beat data=0x0011223344556677, SOP+EOP, empty=0, out_ready=1 -> out beats 0x00112233 (SOP), 0x44556677 (EOP, empty 0) on consecutive cycles.
- Defaults, EOP beat with empty=5 -> single out beat 0x00112233 with SOP=EOP=1 and out_empty=1; in_ready high for the next beat in the same cycle.
- IN_SYMBOLS=16, OUT_SYMBOLS=4, 3-beat packet, last empty=6 -> 4+4+3 out beats; final out_empty=2; SOP only on the first.
- Random out_ready toggling (50%) over 200 packets -> scoreboard byte stream, SOP/EOP/empty all match the reference model; no data lost or duplicated.
- Assert reset_n low during slice k=1 of a 4-slice beat -> outputs 0 next cycle; the first post-reset packet starts cleanly at k=0.
- DFA_SIDEBAND_EN, channel=1, error=1 on a 2-slice beat -> both out beats carry out_channel=1, out_error=1.
